// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller for the single-cycle RV32 core.
//
// It latches rising edges on the external interrupt lines as pending bits,
// picks the highest-priority event on each retiring instruction, saves the
// trap state (mepc/mcause) and asks the fetch mux for a PC redirect.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid         an instruction retires this cycle
//   pc, pc_next         PC of the retiring instruction and its successor
//   int_cause           decoder cause: 0 none, 1/3 illegal, 2 ECALL
//   mret                decoder MRET strobe
//   irq, irq_en         level interrupt lines and per-line enables
//   redirect            fetch mux must take redirect_pc this cycle
//   redirect_pc         redirect target (TRAP_VEC when idle)
//   mepc, mcause        saved return PC and cause
//   in_handler          state is HANDLER
//   pending             latched interrupt edges
//
// Build option: define TRAP_IRQ_SYNC_EN to put a two-flop synchronizer on
// every irq line ahead of edge detection (adds 2 cycles of latency).
//
// State table:
//   state   | meaning
//   RUN     | normal execution, interrupts may be taken
//   HANDLER | inside trap handler, interrupts held pending

module trap_ctrl #(
  parameter int          NUM_IRQ  = 4,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        pc,
  input  logic [31:0]        pc_next,
  input  logic [1:0]         int_cause,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        mepc,
  output logic [31:0]        mcause,
  output logic               in_handler,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

  state_t state, state_nxt;

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] avail;
  logic [NUM_IRQ-1:0] irq_hot;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [4:0]         irq_idx;
  logic               irq_found;
  logic               take_exc;
  logic               take_mret;
  logic               take_irq;
  logic [31:0]        exc_code;

`ifdef TRAP_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq;
`endif

  // Sample register plus previous-value register: an edge captured at
  // clock N becomes a pending bit at N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= '0;
      irq_prev <= '0;
    end else begin
      irq_q    <= irq_s;
      irq_prev <= irq_q;
    end
  end

  assign rise = irq_q & ~irq_prev;

  // Event decode. MRET outside a handler is an illegal instruction.
  always_comb begin
    take_exc  = instr_valid && ((int_cause != 2'd0) || (mret && state == RUN));
    take_mret = instr_valid && !take_exc && mret && (state == HANDLER);
    exc_code  = (int_cause == 2'd2) ? 32'd11 : 32'd2;
    avail     = pending & irq_en;
    irq_hot   = '0;
    irq_idx   = '0;
    irq_found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (avail[i] && !irq_found) begin
        irq_found  = 1'b1;
        irq_idx    = 5'(i);
        irq_hot[i] = 1'b1;
      end
    end
    take_irq = instr_valid && !take_exc && !take_mret && (state == RUN) && irq_found;
    clr_mask = take_irq ? irq_hot : '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (take_exc || take_irq) state_nxt = HANDLER;
    else if (take_mret)       state_nxt = RUN;
  end

  // Outputs
  always_comb begin
    redirect    = take_exc || take_mret || take_irq;
    redirect_pc = take_mret ? mepc : TRAP_VEC;
    in_handler  = (state == HANDLER);
  end

  // Trap state and pending bits; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc    <= '0;
      mcause  <= '0;
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
      if (take_exc) begin
        mepc   <= pc;
        mcause <= exc_code;
      end else if (take_irq) begin
        mepc   <= pc_next;
        mcause <= 32'h8000_0000 | ({27'd0, irq_idx} + 32'd16);
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  localparam int NUM_IRQ = 4;

  logic               clk;
  logic               rst_n;
  logic               instr_valid;
  logic [31:0]        pc;
  logic [31:0]        pc_next;
  logic [1:0]         int_cause;
  logic               mret;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_en;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        mepc;
  logic [31:0]        mcause;
  logic               in_handler;
  logic [NUM_IRQ-1:0] pending;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.NUM_IRQ(NUM_IRQ), .TRAP_VEC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_next     (pc_next),
    .int_cause   (int_cause),
    .mret        (mret),
    .irq         (irq),
    .irq_en      (irq_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mepc        (mepc),
    .mcause      (mcause),
    .in_handler  (in_handler),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [1:0]  cause;
    logic        mret;
    logic [3:0]  irq;
    logic [3:0]  en;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic        e_inh;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] p, input logic [31:0] pn,
                       input logic [1:0] c, input logic m, input logic [3:0] i, input logic [3:0] e);
    instr_valid = iv; pc = p; pc_next = pn; int_cause = c; mret = m; irq = i; irq_en = e;
  endtask

  // Called at posedge+1: drive, check combinational outputs mid-cycle,
  // then check registered state just after the next edge.
  task automatic apply(input vec_t v, input int n);
    drive(v.iv, v.pc, v.pcn, v.cause, v.mret, v.irq, v.en);
    @(negedge clk);
    chk("redirect", n, {31'd0, redirect}, {31'd0, v.e_redir});
    chk("redirect_pc", n, redirect_pc, v.e_rpc);
    @(posedge clk); #1;
    chk("mepc", n, mepc, v.e_mepc);
    chk("mcause", n, mcause, v.e_mcause);
    chk("in_handler", n, {31'd0, in_handler}, {31'd0, v.e_inh});
    chk("pending", n, {28'd0, pending}, {28'd0, v.e_pend});
  endtask

  initial begin
    int lat;
    int exp_lat;

    //          iv    pc          pcn         c     m     irq      en       | rd    rpc         mepc        mcause          inh   pend
    vecs[0]  = '{1'b1, 32'h40,  32'h44,  2'd2, 1'b0, 4'b0000, 4'hF, 1'b1, 32'h100, 32'h40,  32'd11,         1'b1, 4'b0000};
    vecs[1]  = '{1'b1, 32'h44,  32'h48,  2'd0, 1'b1, 4'b0000, 4'hF, 1'b1, 32'h40,  32'h40,  32'd11,         1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 32'h80,  32'h84,  2'd0, 1'b1, 4'b0000, 4'hF, 1'b1, 32'h100, 32'h80,  32'd2,          1'b1, 4'b0000};
    vecs[3]  = '{1'b1, 32'h84,  32'h88,  2'd0, 1'b1, 4'b0000, 4'hF, 1'b1, 32'h80,  32'h80,  32'd2,          1'b0, 4'b0000};
    vecs[4]  = '{1'b0, 32'h0,   32'h0,   2'd0, 1'b0, 4'b1010, 4'hF, 1'b0, 32'h100, 32'h80,  32'd2,          1'b0, 4'b0000};
    vecs[5]  = '{1'b0, 32'h0,   32'h0,   2'd0, 1'b0, 4'b1010, 4'hF, 1'b0, 32'h100, 32'h80,  32'd2,          1'b0, 4'b1010};
    vecs[6]  = '{1'b1, 32'h20,  32'h24,  2'd0, 1'b0, 4'b1010, 4'hF, 1'b1, 32'h100, 32'h24,  32'h8000_0011,  1'b1, 4'b1000};
    vecs[7]  = '{1'b1, 32'h100, 32'h104, 2'd0, 1'b1, 4'b1010, 4'hF, 1'b1, 32'h24,  32'h24,  32'h8000_0011,  1'b0, 4'b1000};
    vecs[8]  = '{1'b1, 32'h24,  32'h28,  2'd0, 1'b0, 4'b1010, 4'hF, 1'b1, 32'h100, 32'h28,  32'h8000_0013,  1'b1, 4'b0000};
    vecs[9]  = '{1'b1, 32'h100, 32'h104, 2'd0, 1'b0, 4'b0000, 4'hF, 1'b0, 32'h100, 32'h28,  32'h8000_0013,  1'b1, 4'b0000};
    vecs[10] = '{1'b0, 32'h0,   32'h0,   2'd0, 1'b0, 4'b0100, 4'hF, 1'b0, 32'h100, 32'h28,  32'h8000_0013,  1'b1, 4'b0000};
    vecs[11] = '{1'b1, 32'h104, 32'h108, 2'd0, 1'b0, 4'b0100, 4'hF, 1'b0, 32'h100, 32'h28,  32'h8000_0013,  1'b1, 4'b0100};
    vecs[12] = '{1'b1, 32'h108, 32'h10C, 2'd2, 1'b0, 4'b0100, 4'hF, 1'b1, 32'h100, 32'h108, 32'd11,         1'b1, 4'b0100};
    vecs[13] = '{1'b0, 32'h10C, 32'h110, 2'd3, 1'b1, 4'b0100, 4'hF, 1'b0, 32'h100, 32'h108, 32'd11,         1'b1, 4'b0100};
    vecs[14] = '{1'b1, 32'h10C, 32'h110, 2'd0, 1'b1, 4'b0100, 4'hF, 1'b1, 32'h108, 32'h108, 32'd11,         1'b0, 4'b0100};
    vecs[15] = '{1'b1, 32'h200, 32'h204, 2'd0, 1'b0, 4'b0100, 4'h0, 1'b0, 32'h100, 32'h108, 32'd11,         1'b0, 4'b0100};
    vecs[16] = '{1'b1, 32'h204, 32'h208, 2'd0, 1'b0, 4'b0100, 4'h4, 1'b1, 32'h100, 32'h208, 32'h8000_0012,  1'b1, 4'b0000};
    vecs[17] = '{1'b1, 32'h300, 32'h304, 2'd3, 1'b0, 4'b0100, 4'hF, 1'b1, 32'h100, 32'h300, 32'd2,          1'b1, 4'b0000};
    vecs[18] = '{1'b1, 32'h304, 32'h308, 2'd0, 1'b1, 4'b0100, 4'hF, 1'b1, 32'h300, 32'h300, 32'd2,          1'b0, 4'b0000};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 4'b0000, 4'h0);
    #1;
    chk("rst_redirect", 0, {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", 0, redirect_pc, 32'h100);
    chk("rst_mepc", 0, mepc, 32'd0);
    chk("rst_mcause", 0, mcause, 32'd0);
    chk("rst_in_handler", 0, {31'd0, in_handler}, 32'd0);
    chk("rst_pending", 0, {28'd0, pending}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) apply(vecs[i], i);

    // Masked line 0 stays pending across ten retires, taken once enabled.
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 4'b0001, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mask_pending", 0, {28'd0, pending}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), 32'h404 + 32'(i * 4), 2'd0, 1'b0, 4'b0001, 4'h0);
      @(negedge clk);
      chk("mask_redirect", i, {31'd0, redirect}, 32'd0);
      @(posedge clk); #1;
    end
    chk("mask_hold", 0, {28'd0, pending}, 32'h1);
    drive(1'b1, 32'h428, 32'h42C, 2'd0, 1'b0, 4'b0001, 4'h1);
    @(negedge clk);
    chk("unmask_redirect", 0, {31'd0, redirect}, 32'd1);
    @(posedge clk); #1;
    chk("unmask_mcause", 0, mcause, 32'h8000_0010);
    chk("unmask_mepc", 0, mepc, 32'h42C);
    chk("unmask_pending", 0, {28'd0, pending}, 32'h0);

    // Asynchronous reset mid-handler with line 2 pending.
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 4'b0101, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_pending", 0, {28'd0, pending}, 32'h4);
    chk("pre_rst_in_handler", 0, {31'd0, in_handler}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 4'b0000, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_handler", 1, {31'd0, in_handler}, 32'd0);
    chk("async_pending", 1, {28'd0, pending}, 32'd0);
    chk("async_mepc", 1, mepc, 32'd0);
    chk("async_mcause", 1, mcause, 32'd0);
    chk("async_redirect", 1, {31'd0, redirect}, 32'd0);
    chk("async_redirect_pc", 1, redirect_pc, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_pending", 0, {28'd0, pending}, 32'd0);

    // Edge-to-pending latency, counted in edges after the sampling edge.
`ifdef TRAP_IRQ_SYNC_EN
    exp_lat = 3;
`else
    exp_lat = 1;
`endif
    irq = 4'b0010;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (pending[1] && lat == 0) lat = i;
    end
    chk("irq_latency", 0, 32'(lat), 32'(exp_lat));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
